lab_nios2_gen2_0_cpu_mulx_seq: RTL and testbench

Multi-pass multiply sequencer that drives the CPU's three-product 16x16 multiplier cell. It accepts a 32x32 multiply request and feeds the cell's operand inputs and enable. It consumes the cell's three registered partial products: lo*lo, src1_lo*src2_hi and src1_hi*src2_lo. It returns either the low result word (MUL) or the high word of the 64-bit product (MULXSS / MULXSU / MULXUU). The hi*hi term is obtained with a second pass through the same cell.

---
 rtl/lab_nios2_gen2_0_cpu_mulx_seq.sv | 164 ++++++++++++++++
 tb/tb_lab_nios2_gen2_0_cpu_mulx_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/lab_nios2_gen2_0_cpu_mulx_seq.sv
// Multi-pass 32x32 multiply sequencer driving a three-product 16x16 multiplier cell.
// Returns the low product word (MUL) or the corrected high word (MULXSS/MULXSU/MULXUU).
module lab_nios2_gen2_0_cpu_mulx_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [31:0] mc_src1,
    output logic [31:0] mc_src2,
    output logic        mc_en,
    input  logic [31:0] mc_p1,
    input  logic [31:0] mc_p2,
    input  logic [31:0] mc_p3
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISS1,
        S_CAP1,
        S_ISS2,
        S_CAP2,
        S_FIX
    } state_t;

    localparam logic [1:0] OP_MUL    = 2'd0;
    localparam logic [1:0] OP_MULXSS = 2'd1;
    localparam logic [1:0] OP_MULXSU = 2'd2;

    state_t       state_q, state_d;
    logic [31:0]  a_q, a_d;
    logic [31:0]  b_q, b_d;
    logic [1:0]   op_q, op_d;
    logic [31:0]  lo_q, lo_d;
    logic [32:0]  mid_q, mid_d;
    logic [63:0]  u64_q, u64_d;
    logic [31:0]  result_q, result_d;
    logic         done_q, done_d;
    logic         busy_q, busy_d;
    logic         mc_en_q, mc_en_d;
    logic [31:0]  mc_src1_q, mc_src1_d;
    logic [31:0]  mc_src2_q, mc_src2_d;

    logic [31:0]  mid32;
    logic [31:0]  hi_word;
    logic [31:0]  corr_a;
    logic [31:0]  corr_b;
    logic         u64_lo_unused;

    // Low product word only feeds the high word through the carry already folded into u64.
    assign u64_lo_unused = ^u64_q[31:0];

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        lo_d      = lo_q;
        mid_d     = mid_q;
        u64_d     = u64_q;
        result_d  = result_q;
        done_d    = 1'b0;
        mid32     = mc_p2 + mc_p3;
        hi_word   = u64_q[63:32];
        corr_a    = a_q[31] ? b_q : 32'h0;
        corr_b    = b_q[31] ? a_q : 32'h0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = src_a;
                    b_d     = src_b;
                    op_d    = op;
                    state_d = S_ISS1;
                end
            end
            S_ISS1: state_d = S_CAP1;
            S_CAP1: begin
                if (op_q == OP_MUL) begin
                    result_d = mc_p1 + (mid32 << 16);
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    lo_d    = mc_p1;
                    mid_d   = {1'b0, mc_p2} + {1'b0, mc_p3};
                    state_d = S_ISS2;
                end
            end
            S_ISS2: state_d = S_CAP2;
            S_CAP2: begin
                u64_d   = {mc_p1, lo_q} + ({31'h0, mid_q} << 16);
                state_d = S_FIX;
            end
            S_FIX: begin
                // Unsigned high word corrected to signed interpretation of the operands.
                case (op_q)
                    OP_MULXSS: result_d = hi_word - corr_a - corr_b;
                    OP_MULXSU: result_d = hi_word - corr_a;
                    default:   result_d = hi_word;
                endcase
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Cell-facing outputs are registered, so they follow the state being entered.
        busy_d    = (state_d != S_IDLE);
        mc_en_d   = (state_d == S_ISS1) || (state_d == S_ISS2);
        mc_src1_d = 32'h0;
        mc_src2_d = 32'h0;
        if (state_d == S_ISS1) begin
            mc_src1_d = a_d;
            mc_src2_d = b_d;
        end else if (state_d == S_ISS2) begin
            mc_src1_d = {16'h0, a_q[31:16]};
            mc_src2_d = {16'h0, b_q[31:16]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            lo_q      <= '0;
            mid_q     <= '0;
            u64_q     <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            mc_en_q   <= 1'b0;
            mc_src1_q <= '0;
            mc_src2_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            lo_q      <= lo_d;
            mid_q     <= mid_d;
            u64_q     <= u64_d;
            result_q  <= result_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            mc_en_q   <= mc_en_d;
            mc_src1_q <= mc_src1_d;
            mc_src2_q <= mc_src2_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;
    assign mc_en   = mc_en_q;
    assign mc_src1 = mc_src1_q;
    assign mc_src2 = mc_src2_q;

endmodule

// File: tb/tb_lab_nios2_gen2_0_cpu_mulx_seq.sv
// Bench for the multiply sequencer: behavioural multiplier cell plus a 64-bit arithmetic
// reference for every operation, with directed corner cases and randomized operands.
module tb_lab_nios2_gen2_0_cpu_mulx_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] mc_src1;
    logic [31:0] mc_src2;
    logic        mc_en;
    logic [31:0] mc_p1 = '0;
    logic [31:0] mc_p2 = '0;
    logic [31:0] mc_p3 = '0;

    int n_tests = 0;
    int n_fail  = 0;

    lab_nios2_gen2_0_cpu_mulx_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .src_a   (src_a),
        .src_b   (src_b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .mc_src1 (mc_src1),
        .mc_src2 (mc_src2),
        .mc_en   (mc_en),
        .mc_p1   (mc_p1),
        .mc_p2   (mc_p2),
        .mc_p3   (mc_p3)
    );

    always #5 clk = ~clk;

    // Multiplier cell: one registered stage, held while mc_en is low.
    always @(posedge clk) begin
        if (mc_en) begin
            mc_p1 <= 32'(mc_src1[15:0]) * 32'(mc_src2[15:0]);
            mc_p2 <= 32'(mc_src1[15:0]) * 32'(mc_src2[31:16]);
            mc_p3 <= 32'(mc_src1[31:16]) * 32'(mc_src2[15:0]);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'h0, a});
        longint ub = longint'({32'h0, b});
        logic [63:0] p;
        case (o)
            2'd1:    p = 64'(sa * sb);
            2'd2:    p = 64'(sa * ub);
            default: p = 64'(ua * ub);
        endcase
        return (o == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    // Issue one operation at the next negedge and follow it to done, checking timing and value.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        int cyc_done = -1;
        int en_mask = 0;
        int busy_mask = 0;
        int lat = (o == 2'd0) ? 3 : 6;
        int exp_en = (o == 2'd0) ? 32'h2 : 32'ha;
        int exp_busy = ((1 << lat) - 1) & ~1;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        src_a = $urandom;
        src_b = $urandom;
        for (int k = 1; k <= 12 && cyc_done < 0; k++) begin
            if (mc_en) en_mask |= (1 << k);
            if (busy) busy_mask |= (1 << k);
            if (done) cyc_done = k;
            if (cyc_done < 0) begin
                @(posedge clk);
                #1;
            end
        end
        check({tag, "_latency"}, 64'(cyc_done), 64'(lat));
        check({tag, "_result"}, {32'h0, result}, {32'h0, ref_mul(o, a, b)});
        check({tag, "_mc_en"}, 64'(en_mask), 64'(exp_en));
        check({tag, "_busy"}, 64'(busy_mask), 64'(exp_busy));
    endtask

    initial begin
        logic [31:0] held;
        int seen;

        // Reset and idle behaviour
        #12;
        check("rst_async_result", {32'h0, result}, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("idle_busy", {63'h0, busy}, 64'h0);
            check("idle_outs", {30'h0, done, mc_en, result}, 64'h0);
            check("idle_srcs", {mc_src1, mc_src2}, 64'h0);
        end

        // Directed cases
        do_op(2'd0, 32'h00010003, 32'h00020005, "mul_dir");
        check("mul_dir_const", {32'h0, result}, 64'h000B000F);
        do_op(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, "uu_ones");
        check("uu_ones_const", {32'h0, result}, 64'hFFFFFFFE);
        do_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, "ss_ones");
        check("ss_ones_const", {32'h0, result}, 64'h00000000);
        do_op(2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, "su_ones");
        check("su_ones_const", {32'h0, result}, 64'hFFFFFFFF);
        do_op(2'd1, 32'h80000000, 32'h80000000, "ss_min");
        check("ss_min_const", {32'h0, result}, 64'h40000000);

        // Result holds between done pulses
        held = result;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("hold_result", {32'h0, result}, {32'h0, held});
        check("hold_no_done", 64'(seen), 64'h0);

        // Start during CAP1 of a MUL is ignored
        @(negedge clk);
        start = 1'b1; op = 2'd0; src_a = 32'h00000007; src_b = 32'h00000009;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        start = 1'b1; op = 2'd3; src_a = 32'h12345678; src_b = 32'h9ABCDEF0;
        @(posedge clk); #1;
        start = 1'b0;
        check("ign_done_cycle3", {63'h0, done}, 64'h1);
        check("ign_result", {32'h0, result}, 64'd63);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        check("ign_no_second_op", 64'(seen), 64'h0);

        // Back-to-back: each do_op starts in the previous done cycle
        do_op(2'd0, 32'h0000FFFF, 32'h0000FFFF, "b2b_first");
        do_op(2'd0, 32'hDEADBEEF, 32'h01234567, "b2b_second");

        // Reset during CAP2 of a MULXUU
        @(negedge clk);
        start = 1'b1; op = 2'd3; src_a = 32'hCAFEF00D; src_b = 32'h87654321;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k < 4; k++) begin
            @(posedge clk); #1;
        end
        check("cap2_busy_before_rst", {63'h0, busy}, 64'h1);
        reset_n = 1'b0;
        #1;
        check("rst_mid_busy_done_en", {61'h0, busy, done, mc_en}, 64'h0);
        check("rst_mid_result", {32'h0, result}, 64'h0);
        check("rst_mid_srcs", {mc_src1, mc_src2}, 64'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        check("rst_mid_no_done", 64'(seen), 64'h0);
        do_op(2'd0, 32'h00010003, 32'h00020005, "mul_after_rst");
        check("mul_after_rst_const", {32'h0, result}, 64'h000B000F);

        // Randomized operations, including sign-heavy operand picks
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (i % 8 == 0) ra[31] = 1'b1;
            if (i % 5 == 0) rb[31] = 1'b1;
            do_op(ro, ra, rb, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
